// File: rtl/nn_run_controller.sv
// Batch initiator for neural_network: fires runs, buffers results in a FWFT FIFO.
// Optional WAIT watchdog enabled by defining NN_TIMEOUT_EN.
module nn_run_controller #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [CNT_W-1:0]  num_runs,
  output logic              nn_start,
  input  logic              nn_ready,
  input  logic [DATA_W-1:0] nn_out,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, FIRE, WAIT, STALL, NEXT
  } state_t;

  state_t state, state_n;

  logic              ready_q;
  logic              rise;
  logic [CNT_W-1:0]  runs_q, cnt_q;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr, wptr_n, rptr_n;
  logic              push, pop, done_n, tmo;
  logic [DATA_W-1:0] wdata;

  assign rise = nn_ready & ~ready_q;
  assign pop  = rd_en & ~empty;
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    wdata    = nn_out;
    done_n   = 1'b0;
    nn_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          if (num_runs != '0) state_n = FIRE;
          else done_n = 1'b1;
        end
      end
      FIRE: begin
        nn_start = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        if (rise) begin
          if (!full) begin
            push    = 1'b1;
            state_n = NEXT;
          end else begin
            state_n = STALL;
          end
        end else if (tmo) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      STALL: begin
        if (!full || rd_en) begin
          push    = 1'b1;
          wdata   = skid_q;
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (CNT_W'(cnt_q + 1'b1) == runs_q) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = FIRE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      runs_q  <= '0;
      cnt_q   <= '0;
      skid_q  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= nn_ready;
      done    <= done_n;
      if (state == IDLE && go) begin
        runs_q <= num_runs;
        cnt_q  <= '0;
      end else if (state == NEXT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state == WAIT && rise && full)
        skid_q <= nn_out;
    end
  end

  assign wptr_n = wptr + (AW+1)'(push);
  assign rptr_n = rptr + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Head register: bypass the write when it lands in the next head slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      empty <= (wptr_n == rptr_n);
      full  <= (wptr_n[AW] != rptr_n[AW]) &&
               (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      if (wptr_n != rptr_n) begin
        if (push && wptr[AW-1:0] == rptr_n[AW-1:0])
          rd_data <= wdata;
        else
          rd_data <= mem[rptr_n[AW-1:0]];
      end
    end
  end

`ifdef NN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          terr_q;

  assign tmo         = (state == WAIT) && (tcnt == TW'(TIMEOUT - 1));
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt   <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state != WAIT) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (tmo && !rise) terr_q <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_nn_run_controller.sv
// Directed self-checking bench for nn_run_controller.
// Define NN_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=16).
module tb_nn_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  num_runs = '0;
  logic        nn_start;
  logic        nn_ready = 1'b0;
  logic [15:0] nn_out = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        empty, full, busy, done, timeout_err;

  int nerr = 0;
  int nchk = 0;

  int          pend = 0;
  int          delay = 2;
  bit          hold = 1'b0;
  logic [15:0] vals[$];
  int          starts = 0;
  int          dones = 0;

  nn_run_controller #(
    .DATA_W(16), .DEPTH(8), .CNT_W(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .num_runs(num_runs),
    .nn_start(nn_start), .nn_ready(nn_ready), .nn_out(nn_out),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // neural_network model: answers each nn_start after `delay` cycles
  initial forever begin
    @(posedge clk); #2;
    if (!rst) begin
      pend = 0;
      nn_ready = 1'b0;
    end else if (nn_start) begin
      starts++;
      pend = (vals.size() > 0) ? delay : 0;
      if (!hold) nn_ready = 1'b0;
    end else if (pend > 0) begin
      pend--;
      nn_ready = (pend == 0) || (hold && nn_ready && pend > 2);
      if (pend == 0) nn_out = vals.pop_front();
    end else if (!hold) begin
      nn_ready = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (done) dones++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_batch(input logic [7:0] n);
    tick();
    go = 1'b1;
    num_runs = n;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    nchk++;
    if ({busy, empty, full, nn_start, done, timeout_err} !== 6'b010000) begin
      nerr++;
      $display("FAIL reset_flags got=%b want=010000",
               {busy, empty, full, nn_start, done, timeout_err});
    end
    nchk++;
    if (rd_data !== 16'h0000) begin
      nerr++;
      $display("FAIL reset_rd_data got=%h want=0000", rd_data);
    end
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    bit ok;
    int s0 = starts;
    int d0 = dones;
    delay = 5;
    vals.push_back(16'h00A5);
    start_batch(8'd1);
    wait_done(60, ok);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL single_done got=timeout want=done");
    end
    nchk++;
    if (busy !== 1'b0 || empty !== 1'b0) begin
      nerr++;
      $display("FAIL single_flags got=busy%b empty%b want=busy0 empty0",
               busy, empty);
    end
    nchk++;
    if (rd_data !== 16'h00A5) begin
      nerr++;
      $display("FAIL single_data got=%h want=00a5", rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    nchk++;
    if (starts - s0 !== 1 || dones - d0 !== 1) begin
      nerr++;
      $display("FAIL single_counts got=starts%0d dones%0d want=1 1",
               starts - s0, dones - d0);
    end
    nchk++;
    if (empty !== 1'b1 || rd_data !== 16'h00A5) begin
      nerr++;
      $display("FAIL single_pop got=empty%b data%h want=1 00a5",
               empty, rd_data);
    end
  endtask

  task automatic test_stuck_high();
    bit ok;
    int s0 = starts;
    int d0 = dones;
    int got = 0;
    delay = 6;
    hold = 1'b1;
    vals.push_back(16'h0001);
    vals.push_back(16'h0002);
    vals.push_back(16'h0003);
    start_batch(8'd3);
    wait_done(200, ok);
    hold = 1'b0;
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL stuck_done got=timeout want=done");
    end
    for (int c = 0; c < 20 && got < 3; c++) begin
      tick();
      rd_en = 1'b0;
      if (!empty) begin
        nchk++;
        if (rd_data !== 16'(got + 1)) begin
          nerr++;
          $display("FAIL stuck_data got=%h want=%h", rd_data, 16'(got + 1));
        end
        got++;
        rd_en = 1'b1;
      end
    end
    tick();
    rd_en = 1'b0;
    tick();
    nchk++;
    if (got !== 3 || empty !== 1'b1) begin
      nerr++;
      $display("FAIL stuck_count got=%0d empty%b want=3 empty1", got, empty);
    end
    nchk++;
    if (starts - s0 !== 3 || dones - d0 !== 1) begin
      nerr++;
      $display("FAIL stuck_pulses got=starts%0d dones%0d want=3 1",
               starts - s0, dones - d0);
    end
  endtask

  task automatic test_backpressure();
    int s0 = starts;
    int d0 = dones;
    int got = 0;
    delay = 2;
    for (int i = 1; i <= 10; i++) vals.push_back(16'(16'h0100 + i));
    start_batch(8'd10);
    repeat (120) tick();
    nchk++;
    if (full !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL bp_stall got=full%b busy%b want=1 1", full, busy);
    end
    nchk++;
    if (starts - s0 !== 9 || dones - d0 !== 0) begin
      nerr++;
      $display("FAIL bp_starts got=starts%0d dones%0d want=9 0",
               starts - s0, dones - d0);
    end
    for (int c = 0; c < 200 && got < 10; c++) begin
      if (c > 0) tick();
      rd_en = 1'b0;
      if (!empty) begin
        nchk++;
        if (rd_data !== 16'(16'h0101 + got)) begin
          nerr++;
          $display("FAIL bp_data got=%h want=%h", rd_data, 16'(16'h0101 + got));
        end
        got++;
        rd_en = 1'b1;
      end
    end
    tick();
    rd_en = 1'b0;
    repeat (5) tick();
    nchk++;
    if (got !== 10 || empty !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drain got=%0d empty%b busy%b want=10 1 0",
               got, empty, busy);
    end
    nchk++;
    if (starts - s0 !== 10 || dones - d0 !== 1) begin
      nerr++;
      $display("FAIL bp_pulses got=starts%0d dones%0d want=10 1",
               starts - s0, dones - d0);
    end
  endtask

  task automatic test_zero_runs();
    int s0 = starts;
    int d0 = dones;
    start_batch(8'd0);
    nchk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL zero_done got=done%b busy%b want=1 0", done, busy);
    end
    repeat (5) tick();
    nchk++;
    if (starts - s0 !== 0 || dones - d0 !== 1) begin
      nerr++;
      $display("FAIL zero_pulses got=starts%0d dones%0d want=0 1",
               starts - s0, dones - d0);
    end
  endtask

  task automatic test_empty_pop();
    bit ok;
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    tick();
    nchk++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 16'h010A) begin
      nerr++;
      $display("FAIL epop_hold got=empty%b full%b data%h want=1 0 010a",
               empty, full, rd_data);
    end
    delay = 3;
    vals.push_back(16'h0BEE);
    start_batch(8'd1);
    wait_done(60, ok);
    tick();
    nchk++;
    if (!ok || empty !== 1'b0 || rd_data !== 16'h0BEE) begin
      nerr++;
      $display("FAIL epop_push got=ok%b empty%b data%h want=1 0 0bee",
               ok, empty, rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    nchk++;
    if (empty !== 1'b1) begin
      nerr++;
      $display("FAIL epop_drain got=empty%b want=1", empty);
    end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    int got = 0;
    delay = 2;
    for (int i = 0; i < 8; i++) vals.push_back(16'(16'h0020 + i));
    start_batch(8'd8);
    wait_done(150, ok);
    nchk++;
    if (!ok || full !== 1'b1) begin
      nerr++;
      $display("FAIL ppf_fill got=ok%b full%b want=1 1", ok, full);
    end
    vals.push_back(16'h0028);
    start_batch(8'd1);
    repeat (20) tick();
    nchk++;
    if (busy !== 1'b1 || full !== 1'b1 || rd_data !== 16'h0020) begin
      nerr++;
      $display("FAIL ppf_stall got=busy%b full%b data%h want=1 1 0020",
               busy, full, rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    nchk++;
    if (full !== 1'b1 || rd_data !== 16'h0021) begin
      nerr++;
      $display("FAIL ppf_same got=full%b data%h want=1 0021", full, rd_data);
    end
    repeat (4) tick();
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (c > 0) tick();
      rd_en = 1'b0;
      if (!empty) begin
        nchk++;
        if (rd_data !== 16'(16'h0021 + got)) begin
          nerr++;
          $display("FAIL ppf_data got=%h want=%h", rd_data, 16'(16'h0021 + got));
        end
        got++;
        rd_en = 1'b1;
      end
    end
    tick();
    rd_en = 1'b0;
    tick();
    nchk++;
    if (got !== 8 || empty !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL ppf_drain got=%0d empty%b busy%b want=8 1 0",
               got, empty, busy);
    end
  endtask

`ifdef NN_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit ok = 1'b0;
    start_batch(8'd2);
    for (int c = 0; c < 100; c++) begin
      tick();
      n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    nchk++;
    if (!ok || n !== 17) begin
      nerr++;
      $display("FAIL tmo_latency got=ok%b cycles%0d want=1 17", ok, n);
    end
    nchk++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL tmo_flags got=err%b busy%b want=1 0", timeout_err, busy);
    end
    repeat (10) tick();
    nchk++;
    if (timeout_err !== 1'b1) begin
      nerr++;
      $display("FAIL tmo_sticky got=%b want=1", timeout_err);
    end
    rst = 1'b0;
    tick();
    nchk++;
    if (timeout_err !== 1'b0) begin
      nerr++;
      $display("FAIL tmo_clear got=%b want=0", timeout_err);
    end
    rst = 1'b1;
    repeat (2) tick();
  endtask
`endif

  task automatic test_reset_midbatch();
    int d0;
    delay = 2;
    vals.push_back(16'h0031);
    vals.push_back(16'h0032);
    vals.push_back(16'h0033);
    start_batch(8'd5);
    repeat (60) tick();
    nchk++;
    if (busy !== 1'b1 || empty !== 1'b0 || timeout_err !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_pre got=busy%b empty%b err%b want=1 0 0",
               busy, empty, timeout_err);
    end
    d0 = dones;
    rst = 1'b0;
    tick();
    nchk++;
    if ({busy, empty, full, nn_start, done} !== 5'b01000) begin
      nerr++;
      $display("FAIL rmid_flags got=%b want=01000",
               {busy, empty, full, nn_start, done});
    end
    rst = 1'b1;
    repeat (5) tick();
    nchk++;
    if (dones !== d0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_nodone got=dones%0d busy%b want=%0d 0",
               dones - d0, busy, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stuck_high();
    test_backpressure();
    test_zero_runs();
    test_empty_pop();
    test_push_pop_full();
`ifdef NN_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midbatch();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
